num_format_row: RTL and testbench

NUM_FORMAT_ROW -- requirements
Module: num_format_row

---
 rtl/num_row_pkg.sv | 31 +++
 rtl/bin_to_bcd.sv | 57 +++++
 rtl/num_format_row.sv | 166 ++++++++++++++++
 tb/tb_num_format_row.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/num_row_pkg.sv
// Shared definitions for the numeric display row: FSM state encoding, ASCII
// constants and digit helpers.
package num_row_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StConvert,
    StCommit
  } state_e;

  localparam logic [7:0] AsciiSpace    = 8'h20;
  localparam logic [7:0] AsciiZero     = 8'h30;
  localparam logic [7:0] AsciiAlphaOff = 8'h37;  // "A" - 10
  localparam logic [7:0] AsciiH        = 8'h48;
  localparam logic [7:0] AsciiD        = 8'h44;
  localparam logic [7:0] AsciiColon    = 8'h3A;

  // Number of hex characters needed to show a value of the given bit width.
  function automatic int unsigned hex_digits(input int unsigned width);
    return (width + 3) / 4;
  endfunction

  // Uppercase ASCII for one hex nibble.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return AsciiZero + {4'h0, nib};
    end
    return AsciiAlphaOff + {4'h0, nib};
  endfunction

endpackage

// File: rtl/bin_to_bcd.sv
// Iterative double-dabble converter: one add-3/shift step per cycle for
// VALUE_WIDTH cycles after start_i. done_o is high during the final step; bcd_o
// holds the result from the following cycle until the next start.
module bin_to_bcd
  import num_row_pkg::*;
#(
  parameter int unsigned VALUE_WIDTH = 16,
  parameter int unsigned DEC_DIGITS  = 5
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic [VALUE_WIDTH-1:0]  value_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [DEC_DIGITS*4-1:0] bcd_o
);

  localparam int unsigned DecW = DEC_DIGITS * 4;
  localparam int unsigned SrW  = DecW + VALUE_WIDTH;
  localparam int unsigned CntW = $clog2(VALUE_WIDTH + 1);

  // BCD field on top, remaining binary bits below; both shift left together.
  logic [SrW-1:0]  sr_q, sr_d;
  logic [CntW-1:0] cnt_q;
  logic [DecW-1:0] adj;

  // One double-dabble step: correct every BCD nibble >= 5, then shift.
  always_comb begin
    adj = sr_q[SrW-1 -: DecW];
    for (int k = 0; k < DEC_DIGITS; k++) begin
      if (sr_q[VALUE_WIDTH + k*4 +: 4] >= 4'd5) begin
        adj[k*4 +: 4] = sr_q[VALUE_WIDTH + k*4 +: 4] + 4'd3;
      end
    end
    sr_d = {adj, sr_q[VALUE_WIDTH-1:0]} << 1;
  end

  // Load on start, then step until the counter runs out.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      sr_q  <= {{DecW{1'b0}}, value_i};
      cnt_q <= CntW'(VALUE_WIDTH);
    end else if (busy_o) begin
      sr_q  <= sr_d;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign busy_o = (cnt_q != '0);
  assign done_o = (cnt_q == CntW'(1));
  assign bcd_o  = sr_q[SrW-1 -: DecW];

endmodule

// File: rtl/num_format_row.sv
// Formats an unsigned value as a 16-column ASCII row "H:<hex>  D:<dec>".
// Optional macro LEADING_ZERO_BLANK_EN blanks leading decimal zeros.
module num_format_row
  import num_row_pkg::*;
#(
  parameter int unsigned VALUE_WIDTH = 16,
  parameter int unsigned DEC_DIGITS  = 5
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [VALUE_WIDTH-1:0] value_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic                   done_o,
  input  logic [3:0]             outputCharIndex_i,
  output logic [7:0]             outByte_o
);

  localparam int unsigned HEX_DIGITS = hex_digits(VALUE_WIDTH);
  localparam int unsigned HexW       = HEX_DIGITS * 4;
  localparam int unsigned DecW       = DEC_DIGITS * 4;

  state_e                 state_q, state_d;
  logic [VALUE_WIDTH-1:0] value_q;
  logic [HexW-1:0]        hex_q, value_ext;
  logic [DecW-1:0]        dec_q, conv_bcd;
  logic                   done_q;
  logic [7:0]             out_byte_q, char_d;
  logic                   accept, commit, conv_busy, conv_done;
  logic [DEC_DIGITS-1:0]  blank;

  bin_to_bcd #(
    .VALUE_WIDTH(VALUE_WIDTH),
    .DEC_DIGITS (DEC_DIGITS)
  ) u_bin_to_bcd (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .start_i(accept),
    .value_i(value_i),
    .busy_o (conv_busy),
    .done_o (conv_done),
    .bcd_o  (conv_bcd)
  );

  // Next-state logic: accept in idle, wait for the converter, commit once.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (valid_i) begin
          accept  = 1'b1;
          state_d = StConvert;
        end
      end
      StConvert: begin
        if (conv_done) begin
          state_d = StCommit;
        end else if (!conv_busy) begin
          state_d = StIdle;  // converter lost its job; recover rather than hang
        end
      end
      StCommit: begin
        commit  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, latched value, display registers and done pulse.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      value_q <= '0;
      hex_q   <= '0;
      dec_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= commit;
      if (accept) begin
        value_q <= value_i;
      end
      if (commit) begin
        hex_q <= value_ext;
        dec_q <= conv_bcd;
      end
    end
  end

  // Zero-extend the value to a whole number of nibbles.
  always_comb begin
    value_ext = '0;
    value_ext[VALUE_WIDTH-1:0] = value_q;
  end

  // Leading-zero mask for the decimal field; the units digit is never blank.
  always_comb begin
    blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic lead;
      lead = 1'b1;
      for (int j = DEC_DIGITS - 1; j >= 1; j--) begin
        lead     = lead && (dec_q[j*4 +: 4] == 4'd0);
        blank[j] = lead;
      end
    end
`else
    blank = '0;
`endif
  end

  // Column decode from the committed display registers only.
  always_comb begin
    int unsigned idx;
    int unsigned nib;
    logic [3:0]  digit;
    logic        is_blank;
    idx      = {28'd0, outputCharIndex_i};
    nib      = 0;
    digit    = 4'd0;
    is_blank = 1'b0;
    char_d   = AsciiSpace;
    if (idx == 0) begin
      char_d = AsciiH;
    end else if (idx == 1) begin
      char_d = AsciiColon;
    end else if (idx >= 2 && idx <= HEX_DIGITS + 1) begin
      nib = HEX_DIGITS + 1 - idx;
      for (int k = 0; k < HEX_DIGITS; k++) begin
        if (nib == k) digit = hex_q[k*4 +: 4];
      end
      char_d = hex_ascii(digit);
    end else if (idx == 14 - DEC_DIGITS) begin
      char_d = AsciiD;
    end else if (idx == 15 - DEC_DIGITS) begin
      char_d = AsciiColon;
    end else if (idx >= 16 - DEC_DIGITS) begin
      nib = 15 - idx;
      for (int k = 0; k < DEC_DIGITS; k++) begin
        if (nib == k) begin
          digit    = dec_q[k*4 +: 4];
          is_blank = blank[k];
        end
      end
      char_d = is_blank ? AsciiSpace : (AsciiZero + {4'h0, digit});
    end
  end

  // One-cycle registered character output.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_byte_q <= AsciiSpace;
    end else begin
      out_byte_q <= char_d;
    end
  end

  assign ready_o   = (state_q == StIdle);
  assign done_o    = done_q;
  assign outByte_o = out_byte_q;

endmodule

// File: tb/tb_num_format_row.sv
// Directed bench for num_format_row: default 16/5 instance plus an 8/3 instance.
module tb_num_format_row;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [3:0]  idx;
  logic [15:0] value16;
  logic        valid16, ready16, done16;
  logic [7:0]  out16;
  logic [7:0]  value8;
  logic        valid8, ready8, done8;
  logic [7:0]  out8;

  int checks   = 0;
  int failures = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [127:0] Rst16  = "H:0000   D:    0";
  localparam logic [127:0] Rst8   = "H:00       D:  0";
  localparam logic [127:0] Row1234 = "H:1234   D: 4660";
  localparam logic [127:0] Row0007 = "H:0007   D:    7";
  localparam logic [127:0] Row0100 = "H:0100   D:  256";
`else
  localparam logic [127:0] Rst16  = "H:0000   D:00000";
  localparam logic [127:0] Rst8   = "H:00       D:000";
  localparam logic [127:0] Row1234 = "H:1234   D:04660";
  localparam logic [127:0] Row0007 = "H:0007   D:00007";
  localparam logic [127:0] Row0100 = "H:0100   D:00256";
`endif
  localparam logic [127:0] RowFFFF = "H:FFFF   D:65535";
  localparam logic [127:0] RowFF   = "H:FF       D:255";

  num_format_row dut16 (
    .clk_i            (clk),
    .reset_i          (reset),
    .value_i          (value16),
    .valid_i          (valid16),
    .ready_o          (ready16),
    .done_o           (done16),
    .outputCharIndex_i(idx),
    .outByte_o        (out16)
  );

  num_format_row #(
    .VALUE_WIDTH(8),
    .DEC_DIGITS (3)
  ) dut8 (
    .clk_i            (clk),
    .reset_i          (reset),
    .value_i          (value8),
    .valid_i          (valid8),
    .ready_o          (ready8),
    .done_o           (done8),
    .outputCharIndex_i(idx),
    .outByte_o        (out8)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic check_row(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s observed=\"%s\" expected=\"%s\"", tag, act, exp);
    end
  endtask

  // Scan all 16 columns of both instances; outByte lags the index by one edge.
  task automatic read_rows(output logic [127:0] r16, output logic [127:0] r8);
    for (int i = 0; i < 16; i++) begin
      idx = 4'(i);
      tick;
      r16[127-8*i -: 8] = out16;
      r8[127-8*i -: 8]  = out8;
    end
  endtask

  // Edges are numbered with the acceptance edge as 1; call right after it.
  task automatic run_window(input int n, output int first16, output int first8,
                            output int cnt16, output int cnt8);
    first16 = 0;
    first8  = 0;
    cnt16   = 0;
    cnt8    = 0;
    for (int e = 2; e < n + 2; e++) begin
      tick;
      if (done16 === 1'b1) begin
        cnt16++;
        if (first16 == 0) first16 = e;
      end
      if (done8 === 1'b1) begin
        cnt8++;
        if (first8 == 0) first8 = e;
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] r16, r8;
    int f16, f8, c16, c8;
    int lowrun, runs;

    reset   = 1'b1;
    idx     = 4'd0;
    value16 = 16'h0;
    valid16 = 1'b0;
    value8  = 8'h0;
    valid8  = 1'b0;

    // Reset state.
    tick;
    tick;
    check_val("rst_out16", out16, 8'h20);
    check_val("rst_out8", out8, 8'h20);
    check_val("rst_ready16", ready16, 1);
    check_val("rst_done16", done16, 0);
    check_val("rst_ready8", ready8, 1);
    reset = 1'b0;
    read_rows(r16, r8);
    check_row("rst_row16", r16, Rst16);
    check_row("rst_row8", r8, Rst8);

    // Full-scale values on both instances; latency and single done pulse.
    check_val("pre_ready16", ready16, 1);
    value16 = 16'hFFFF;
    valid16 = 1'b1;
    value8  = 8'd255;
    valid8  = 1'b1;
    tick;
    valid16 = 1'b0;
    valid8  = 1'b0;
    check_val("busy_ready16", ready16, 0);
    run_window(30, f16, f8, c16, c8);
    check_val("lat16", f16, 18);
    check_val("lat8", f8, 10);
    check_val("pulses16", c16, 1);
    check_val("pulses8", c8, 1);
    read_rows(r16, r8);
    check_row("row_ffff", r16, RowFFFF);
    check_row("row_ff", r8, RowFF);

    // Request during conversion is ignored, input change has no effect.
    value16 = 16'h1234;
    valid16 = 1'b1;
    tick;
    valid16 = 1'b0;
    tick;
    tick;
    value16 = 16'h5678;
    valid16 = 1'b1;
    check_val("ignore_ready16", ready16, 0);
    tick;
    valid16 = 1'b0;
    run_window(30, f16, f8, c16, c8);
    check_val("ignore_pulses16", c16, 1);
    read_rows(r16, r8);
    check_row("row_1234", r16, Row1234);

    // Reset in CONVERT cycle 5 aborts and restores the reset image.
    value16 = 16'h00A5;
    valid16 = 1'b1;
    tick;
    valid16 = 1'b0;
    tick;
    tick;
    tick;
    tick;
    reset = 1'b1;
    tick;
    check_val("abort_ready16", ready16, 1);
    check_val("abort_done16", done16, 0);
    check_val("abort_out16", out16, 8'h20);
    reset = 1'b0;
    run_window(25, f16, f8, c16, c8);
    check_val("abort_pulses16", c16, 0);
    read_rows(r16, r8);
    check_row("abort_row16", r16, Rst16);
    check_row("abort_row8", r8, Rst8);
    value16 = 16'h0007;
    valid16 = 1'b1;
    tick;
    valid16 = 1'b0;
    run_window(25, f16, f8, c16, c8);
    check_val("lat_0007", f16, 18);
    read_rows(r16, r8);
    check_row("row_0007", r16, Row0007);

    // valid held high: back-to-back acceptances on each done cycle.
    value16 = 16'h0100;
    valid16 = 1'b1;
    lowrun  = 0;
    runs    = 0;
    for (int c = 0; c < 60; c++) begin
      if (ready16 !== 1'b1) begin
        lowrun++;
      end else begin
        if (lowrun > 0) begin
          check_val("hold_low_run", lowrun, 17);
          check_val("hold_done_with_ready", done16, 1);
          runs++;
        end
        lowrun = 0;
      end
      tick;
    end
    check_val("hold_runs", runs, 3);
    valid16 = 1'b0;
    run_window(25, f16, f8, c16, c8);
    check_val("hold_tail_pulses", c16, 1);
    read_rows(r16, r8);
    check_row("row_0100", r16, Row0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
